// File: rtl/spi_dma_seq_pkg.sv
// rtl/spi_dma_seq_pkg.sv - shared encodings for the SPI block-transfer sequencer
// Contents: FSM state encoding, transfer direction codes, RX fill byte.
package spi_dma_seq_pkg;

   // S_SETTLE is the extra clock after the engine drops spi_busy, so that
   // spi_dout is stable in both CPHA modes before it is captured.
   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_SEND   = 3'd2,
      S_WAIT   = 3'd3,
      S_SETTLE = 3'd4,
      S_STORE  = 3'd5,
      S_NEXT   = 3'd6,
      S_DONE   = 3'd7
   } state_t;

   localparam logic       DIR_TX    = 1'b0;
   localparam logic       DIR_RX    = 1'b1;
   localparam logic [7:0] FILL_BYTE = 8'hFF;

endpackage

// File: rtl/spi_dma_seq_if.sv
// rtl/spi_dma_seq_if.sv - sequencer side bus to the SPI byte engine and memory
// Engine: spi_dma_req/spi_dma_din out, spi_start/spi_busy/spi_dout in.
// Memory: mem_addr/mem_rd/mem_wr/mem_wdata out, mem_rdata/mem_ack in.
interface spi_dma_seq_if #(
   parameter int ADDR_W = 21
) ();
   logic              spi_dma_req;
   logic [7:0]        spi_dma_din;
   logic              spi_start;
   logic              spi_busy;
   logic [7:0]        spi_dout;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd;
   logic              mem_wr;
   logic [7:0]        mem_wdata;
   logic [7:0]        mem_rdata;
   logic              mem_ack;

   modport master (
      output spi_dma_req, spi_dma_din, mem_addr, mem_rd, mem_wr, mem_wdata,
      input  spi_start, spi_busy, spi_dout, mem_rdata, mem_ack
   );

   modport slave (
      input  spi_dma_req, spi_dma_din, mem_addr, mem_rd, mem_wr, mem_wdata,
      output spi_start, spi_busy, spi_dout, mem_rdata, mem_ack
   );
endinterface

// File: rtl/spi_req_arb.sv
// rtl/spi_req_arb.sv - CPU / DMA request gating for the shared SPI engine
// Inputs : idle (sequencer in IDLE), xfer_busy, cfg_start, cpu_req_in,
//          spi_busy, spi_start.
// Outputs: cpu_req_out, cpu_stall, accept (start latched), go (leave IDLE),
//          pend (start is waiting for the engine).
module spi_req_arb (
   input  logic clk,
   input  logic rst_n,
   input  logic idle,
   input  logic xfer_busy,
   input  logic cfg_start,
   input  logic cpu_req_in,
   input  logic spi_busy,
   input  logic spi_start,
   output logic cpu_req_out,
   output logic cpu_stall,
   output logic accept,
   output logic go,
   output logic pend
);

   logic pend_r;
   logic engine_free;

   // A start is only honoured from IDLE and when no transfer is already owned.
   assign accept = idle & cfg_start & ~xfer_busy;

   // The engine is free only when it is neither shifting, nor acknowledging,
   // nor being asked for a CPU byte this cycle (the CPU wins a tie).
   assign engine_free = ~spi_busy & ~spi_start & ~cpu_req_in;
   assign go          = idle & (accept | pend_r) & engine_free;
   assign pend        = pend_r;

   assign cpu_req_out = idle & cpu_req_in;
   assign cpu_stall   = ~idle & cpu_req_in;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_r <= 1'b0;
      end else if (go) begin
         pend_r <= 1'b0;
      end else if (accept) begin
         pend_r <= 1'b1;
      end
   end

endmodule

// File: rtl/spi_dma_seq.sv
// rtl/spi_dma_seq.sv - block-transfer sequencer in front of the SPI byte engine
// Config : cfg_addr, cfg_len (0 = 2^LEN_W), cfg_dir, cfg_start, cfg_abort.
// Status : stat_busy, stat_done (1-clock pulse).
// CPU    : cpu_req_in -> cpu_req_out, cpu_stall.
// bus    : engine request/data and memory read/write handshakes.
module spi_dma_seq
   import spi_dma_seq_pkg::*;
#(
   parameter int ADDR_W = 21,
   parameter int LEN_W  = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [ADDR_W-1:0] cfg_addr,
   input  logic [LEN_W-1:0]  cfg_len,
   input  logic              cfg_dir,
   input  logic              cfg_start,
   input  logic              cfg_abort,
   output logic              stat_busy,
   output logic              stat_done,
   input  logic              cpu_req_in,
   output logic              cpu_req_out,
   output logic              cpu_stall,
   spi_dma_seq_if.master     bus
);

   state_t            state, state_nx;
   logic [ADDR_W-1:0] addr_r;
   logic [LEN_W-1:0]  len_r;
   logic              dir_r;
   logic              abort_r;
   logic              busy_r;
   logic              spi_busy_q;
   logic [7:0]        din_r;
   logic [7:0]        rx_r;

   logic is_idle, accept, go, pend, go_dir, spi_fall, last_byte;
   logic mem_rd_c, mem_wr_c, dma_req_c, done_c;

   assign is_idle = (state == S_IDLE);

   spi_req_arb u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .idle        (is_idle),
      .xfer_busy   (busy_r),
      .cfg_start   (cfg_start),
      .cpu_req_in  (cpu_req_in),
      .spi_busy    (bus.spi_busy),
      .spi_start   (bus.spi_start),
      .cpu_req_out (cpu_req_out),
      .cpu_stall   (cpu_stall),
      .accept      (accept),
      .go          (go),
      .pend        (pend)
   );

   // A pended start already latched its direction; a same-cycle start has not.
   assign go_dir    = pend ? dir_r : cfg_dir;
   assign spi_fall  = spi_busy_q & ~bus.spi_busy;
   // len_r == 1 here means the byte just finished was the last one; a length
   // of 0 wraps through all 2^LEN_W values first.
   assign last_byte = (len_r == LEN_W'(1)) | abort_r | cfg_abort;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:   if (go) state_nx = (go_dir == DIR_RX) ? S_SEND : S_FETCH;
         S_FETCH:  if (bus.mem_ack) state_nx = S_SEND;
         S_SEND:   if (bus.spi_start) state_nx = S_WAIT;
         S_WAIT:   if (spi_fall) state_nx = S_SETTLE;
         S_SETTLE: state_nx = (dir_r == DIR_RX) ? S_STORE : S_NEXT;
         S_STORE:  if (bus.mem_ack) state_nx = S_NEXT;
         S_NEXT: begin
            if (last_byte)            state_nx = S_DONE;
            else if (dir_r == DIR_RX) state_nx = S_SEND;
            else                      state_nx = S_FETCH;
         end
         S_DONE:   state_nx = S_IDLE;
         default:  state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      mem_rd_c  = 1'b0;
      mem_wr_c  = 1'b0;
      dma_req_c = 1'b0;
      done_c    = 1'b0;
      case (state)
         S_FETCH: mem_rd_c  = 1'b1;
         S_SEND:  dma_req_c = 1'b1;
         S_STORE: mem_wr_c  = 1'b1;
         S_DONE:  done_c    = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_r     <= '0;
         len_r      <= '0;
         dir_r      <= DIR_TX;
         abort_r    <= 1'b0;
         busy_r     <= 1'b0;
         spi_busy_q <= 1'b0;
         din_r      <= FILL_BYTE;
         rx_r       <= 8'h00;
      end else begin
         spi_busy_q <= bus.spi_busy;

         if (accept) begin
            addr_r <= cfg_addr;
            len_r  <= cfg_len;
            dir_r  <= cfg_dir;
            busy_r <= 1'b1;
            if (cfg_dir == DIR_RX) din_r <= FILL_BYTE;
         end

         if (state == S_FETCH && bus.mem_ack) din_r <= bus.mem_rdata;
         if (state == S_SETTLE)               rx_r  <= bus.spi_dout;

         if (state == S_NEXT) begin
            addr_r <= addr_r + ADDR_W'(1);
            len_r  <= len_r - LEN_W'(1);
            if (last_byte) busy_r <= 1'b0;
         end

         // Abort is sticky so the in-flight byte (and its STORE) completes.
         if (state == S_DONE) begin
            abort_r <= 1'b0;
         end else if (cfg_abort && state != S_IDLE) begin
            abort_r <= 1'b1;
         end
      end
   end

   assign stat_busy       = busy_r;
   assign stat_done       = done_c;
   assign bus.spi_dma_req = dma_req_c;
   assign bus.spi_dma_din = din_r;
   assign bus.mem_addr    = addr_r;
   assign bus.mem_rd      = mem_rd_c;
   assign bus.mem_wr      = mem_wr_c;
   assign bus.mem_wdata   = rx_r;

endmodule
